// File: rtl/cell_state_updater.sv
// Cell-state updater: c_t = f*c_prev + i*g for each element of a vector.
// Products arrive from an upstream multiplier in pairs (f*c_prev then i*g).
// Each product is rounded, rescaled and saturated from the product Q-format
// back to the state Q-format. The two halves are then summed and saturated again.
// Outputs are registered; busy is decoded straight from the state register.
module cell_state_updater #(
  parameter int DATA_WIDTH   = 16,
  parameter int OUTPUT_WIDTH = 32,
  parameter int FRAC_BITS    = 8,
  parameter int NUM_UNITS    = 64
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic                               prod_done,
  input  logic signed [OUTPUT_WIDTH-1:0]     prod,
  output logic signed [DATA_WIDTH-1:0]       c_out,
  output logic                               c_valid,
  output logic [$clog2(NUM_UNITS)-1:0]       c_index,
  output logic                               busy,
  output logic                               done,
  output logic                               overflow
);

  localparam int IDX_W = $clog2(NUM_UNITS);
  localparam int DW    = DATA_WIDTH;
  localparam int OW    = OUTPUT_WIDTH;

  // Rounding constant and saturation bounds, all at the widened rescale width.
  localparam logic signed [OW:0] ROUND = {{OW{1'b0}}, 1'b1} << (FRAC_BITS - 1);
  localparam logic signed [OW:0] MAX_R = {{(OW-DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [OW:0] MIN_R = {{(OW-DW+2){1'b1}}, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] MAX_D = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] MIN_D = {1'b1, {(DW-1){1'b0}}};
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_UNITS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_FC = 2'd1,
    ACC_IG = 2'd2,
    FINISH = 2'd3
  } state_t;

  // Round-half-up then arithmetic shift; one extra bit keeps the add from wrapping.
  function automatic logic signed [OW:0] rescale(input logic signed [OW-1:0] p);
    logic signed [OW:0] ext;
    ext = {p[OW-1], p} + ROUND;
    return ext >>> FRAC_BITS;
  endfunction

  // True when a rescaled product does not fit the state width.
  function automatic logic r_out_of_range(input logic signed [OW:0] v);
    return (v > MAX_R) || (v < MIN_R);
  endfunction

  // Clamp a rescaled product to the state width.
  function automatic logic signed [DW-1:0] clamp_r(input logic signed [OW:0] v);
    logic signed [DW-1:0] res;
    if (v > MAX_R) begin
      res = MAX_D;
    end else if (v < MIN_R) begin
      res = MIN_D;
    end else begin
      res = v[DW-1:0];
    end
    return res;
  endfunction

  // A DW+1 bit sum overflowed when its top two bits disagree.
  function automatic logic s_out_of_range(input logic signed [DW:0] s);
    return s[DW] != s[DW-1];
  endfunction

  // Clamp a DW+1 bit sum to the state width.
  function automatic logic signed [DW-1:0] clamp_s(input logic signed [DW:0] s);
    logic signed [DW-1:0] res;
    if (s[DW] != s[DW-1]) begin
      res = s[DW] ? MIN_D : MAX_D;
    end else begin
      res = s[DW-1:0];
    end
    return res;
  endfunction

  state_t                state, state_n;
  logic signed [DW-1:0]  r_fc, r_fc_n;
  logic [IDX_W-1:0]      idx, idx_n;
  logic signed [DW-1:0]  c_out_n;
  logic [IDX_W-1:0]      c_index_n;
  logic                  c_valid_n;
  logic                  done_n;
  logic                  overflow_n;

  logic signed [OW:0]    r_now;
  logic signed [DW-1:0]  r_sat;
  logic                  r_ovf;
  logic signed [DW:0]    sum;
  logic signed [DW-1:0]  sum_sat;
  logic                  sum_ovf;

  // Datapath: rescale the incoming product and form the saturated pair sum.
  always_comb begin
    r_now   = rescale(prod);
    r_sat   = clamp_r(r_now);
    r_ovf   = r_out_of_range(r_now);
    sum     = {r_fc[DW-1], r_fc} + {r_sat[DW-1], r_sat};
    sum_sat = clamp_s(sum);
    sum_ovf = s_out_of_range(sum);
  end

  // Next-state and next-output decode; every value holds unless updated.
  always_comb begin
    state_n    = state;
    r_fc_n     = r_fc;
    idx_n      = idx;
    c_out_n    = c_out;
    c_index_n  = c_index;
    c_valid_n  = 1'b0;
    done_n     = 1'b0;
    overflow_n = overflow;
    case (state)
      IDLE: begin
        if (start) begin
          state_n    = ACC_FC;
          idx_n      = '0;
          overflow_n = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      ACC_FC: begin
        if (prod_done) begin
          r_fc_n     = r_sat;
          overflow_n = overflow | r_ovf;
          state_n    = ACC_IG;
        end else begin
          state_n = ACC_FC;
        end
      end
      ACC_IG: begin
        if (prod_done) begin
          c_out_n    = sum_sat;
          c_index_n  = idx;
          c_valid_n  = 1'b1;
          overflow_n = overflow | r_ovf | sum_ovf;
          if (idx == LAST_IDX) begin
            state_n = FINISH;
          end else begin
            idx_n   = idx + IDX_W'(1);
            state_n = ACC_FC;
          end
        end else begin
          state_n = ACC_IG;
        end
      end
      FINISH: begin
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Registered datapath and output flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fc     <= '0;
      idx      <= '0;
      c_out    <= '0;
      c_index  <= '0;
      c_valid  <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      r_fc     <= r_fc_n;
      idx      <= idx_n;
      c_out    <= c_out_n;
      c_index  <= c_index_n;
      c_valid  <= c_valid_n;
      done     <= done_n;
      overflow <= overflow_n;
    end
  end

  assign busy = (state != IDLE);

endmodule
